// File: rtl/rv_issue_pkg.sv
// rv_issue_pkg: shared types for the RV32IM-subset issue queue.
// Holds opcode constants, the 4-bit ALU operation encoding, the dispatch
// class encoding, the decoded instruction record and the ALU funct3 mapping.
package rv_issue_pkg;

    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;

    localparam logic [6:0] F7Base   = 7'b0000000;
    localparam logic [6:0] F7Alt    = 7'b0100000;
    localparam logic [6:0] F7Muldiv = 7'b0000001;

    typedef enum logic [3:0] {
        OpAdd  = 4'd0,
        OpSub  = 4'd1,
        OpAnd  = 4'd2,
        OpOr   = 4'd3,
        OpXor  = 4'd4,
        OpSlt  = 4'd5,
        OpMul  = 4'd6,
        OpDiv  = 4'd7,
        OpSll  = 4'd8,
        OpSrl  = 4'd9,
        OpSra  = 4'd10,
        OpSltu = 4'd11,
        OpMulh = 4'd12,
        OpDivu = 4'd13,
        OpRem  = 4'd14,
        OpRemu = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        ClassLoad   = 2'd0,
        ClassStore  = 2'd1,
        ClassAlu    = 2'd2,
        ClassMuldiv = 2'd3
    } class_e;

    typedef struct packed {
        class_e      cls;
        alu_op_e     op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        use_imm;
        logic        is_branch;
        logic        legal;
    } decoded_t;

    // alt is instr[30]; it only matters for ADD/SUB and SRL/SRA.
    function automatic alu_op_e alu_op(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? OpSub : OpAdd;
            3'b001:  return OpSll;
            3'b010:  return OpSlt;
            3'b011:  return OpSltu;
            3'b100:  return OpXor;
            3'b101:  return alt ? OpSra : OpSrl;
            3'b110:  return OpOr;
            default: return OpAnd;
        endcase
    endfunction

endpackage

// File: rtl/rv_issue_decode.sv
// rv_issue_decode: purely combinational RV32IM-subset decoder.
// Ports:
//   instr - 32-bit instruction word
//   dec   - decoded record (class, op, register indices, 32-bit immediate,
//           use_imm, is_branch, legal)
module rv_issue_decode
    import rv_issue_pkg::*;
(
    input  logic [31:0] instr,
    output decoded_t    dec
);

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_j;

    assign opcode = instr[6:0];
    assign funct7 = instr[31:25];
    assign funct3 = instr[14:12];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        dec       = '0;
        dec.cls   = ClassAlu;
        dec.op    = OpAdd;
        dec.rs1   = instr[19:15];
        dec.rs2   = instr[24:20];
        dec.rd    = instr[11:7];
        case (opcode)
            OpcLoad: begin
                dec.cls     = ClassLoad;
                dec.imm     = imm_i;
                dec.use_imm = 1'b1;
                dec.legal   = 1'b1;
            end
            OpcStore: begin
                dec.cls   = ClassStore;
                dec.imm   = imm_s;
                dec.legal = 1'b1;
            end
            OpcOp: begin
                if (funct7 == F7Muldiv) begin
                    dec.cls   = ClassMuldiv;
                    dec.legal = 1'b1;
                    case (funct3)
                        3'b000:  dec.op = OpMul;
                        3'b001:  dec.op = OpMulh;
                        3'b100:  dec.op = OpDiv;
                        3'b101:  dec.op = OpDivu;
                        3'b110:  dec.op = OpRem;
                        3'b111:  dec.op = OpRemu;
                        default: dec.legal = 1'b0;
                    endcase
                end else if (funct7 == F7Base || funct7 == F7Alt) begin
                    dec.op    = alu_op(funct3, instr[30]);
                    dec.legal = 1'b1;
                end
            end
            OpcOpImm: begin
                // The immediate occupies funct7, so only shifts look at bit 30.
                dec.op      = alu_op(funct3, (funct3 == 3'b101) && instr[30]);
                dec.imm     = imm_i;
                dec.use_imm = 1'b1;
                dec.legal   = 1'b1;
            end
            OpcBranch: begin
                dec.op        = OpSub;
                dec.imm       = imm_b;
                dec.is_branch = 1'b1;
                dec.legal     = 1'b1;
            end
            OpcJal: begin
                dec.imm       = imm_j;
                dec.use_imm   = 1'b1;
                dec.is_branch = 1'b1;
                dec.legal     = 1'b1;
            end
            default: dec.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv_issue_queue.sv
// rv_issue_queue: IQ_DEPTH-entry in-order instruction queue feeding the
// LOAD/STORE/ALU/MULDIV reservation stations. The head entry is decoded
// combinationally and held until its class reports ready.
// Ports:
//   clk, rst_n                  - clock, async active-low reset
//   in_valid/in_ready/in_instr/in_pc - fetch side enqueue
//   flush                       - synchronous clear (drops enqueue/dispatch)
//   disp_valid/disp_ready       - one-hot per-class dispatch handshake
//   disp_alu_op, disp_rs1/rs2/rd, disp_imm, disp_use_imm, disp_is_branch,
//   disp_pc                     - head payload
//   illegal                     - sticky, head is undecodable
//   occupancy                   - number of valid entries
// Optional: define RV_ISSUE_PERF_CNT_EN to add stall_cycles and
// issued_count performance counters (CNT_W wide, wrapping, flush-immune).
module rv_issue_queue
    import rv_issue_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned IQ_DEPTH = 4
`ifdef RV_ISSUE_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W    = 32
`endif
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [31:0]                 in_instr,
    input  logic [XLEN-1:0]             in_pc,
    input  logic                        flush,
    output logic [3:0]                  disp_valid,
    input  logic [3:0]                  disp_ready,
    output logic [3:0]                  disp_alu_op,
    output logic [4:0]                  disp_rs1,
    output logic [4:0]                  disp_rs2,
    output logic [4:0]                  disp_rd,
    output logic [XLEN-1:0]             disp_imm,
    output logic                        disp_use_imm,
    output logic                        disp_is_branch,
    output logic [XLEN-1:0]             disp_pc,
    output logic                        illegal,
    output logic [$clog2(IQ_DEPTH):0]   occupancy
`ifdef RV_ISSUE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]            stall_cycles,
    output logic [CNT_W-1:0]            issued_count
`endif
);

    localparam int unsigned PtrW    = $clog2(IQ_DEPTH);
    localparam logic [PtrW:0] CntFull = (PtrW+1)'(IQ_DEPTH);
    localparam logic [PtrW:0] CntOne  = (PtrW+1)'(1);
    localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

    logic [31:0]     instr_mem [IQ_DEPTH];
    logic [XLEN-1:0] pc_mem    [IQ_DEPTH];

    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic            illegal_q, illegal_d;

    logic     empty;
    logic     enq;
    logic     deq;
    decoded_t dec;

    rv_issue_decode u_decode (
        .instr (instr_mem[rd_ptr_q]),
        .dec   (dec)
    );

    assign empty    = (count_q == '0);
    assign in_ready = (count_q != CntFull);
    assign enq      = in_valid && in_ready && !flush;
    assign deq      = |(disp_valid & disp_ready) && !flush;

    // Also gated on legal so an undecodable head never requests dispatch in
    // the cycle before the sticky flag is set.
    assign disp_valid     = (!empty && !illegal_q && dec.legal) ? (4'b0001 << dec.cls) : 4'b0000;
    assign disp_alu_op    = dec.op;
    assign disp_rs1       = dec.rs1;
    assign disp_rs2       = dec.rs2;
    assign disp_rd        = dec.rd;
    assign disp_imm       = XLEN'($signed(dec.imm));
    assign disp_use_imm   = dec.use_imm;
    assign disp_is_branch = dec.is_branch;
    assign disp_pc        = pc_mem[rd_ptr_q];
    assign illegal        = illegal_q;
    assign occupancy      = count_q;

    always_ff @(posedge clk) begin
        if (enq) begin
            instr_mem[wr_ptr_q] <= in_instr;
            pc_mem[wr_ptr_q]    <= in_pc;
        end
    end

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        illegal_d = illegal_q;
        if (flush) begin
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            count_d   = '0;
            illegal_d = 1'b0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + PtrOne;
            if (deq) rd_ptr_d = rd_ptr_q + PtrOne;
            if (enq && !deq) count_d = count_q + CntOne;
            if (!enq && deq) count_d = count_q - CntOne;
            if (!empty && !dec.legal) illegal_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef RV_ISSUE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] issued_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q  <= '0;
            issued_q <= '0;
        end else begin
            if (|(disp_valid & ~disp_ready)) stall_q <= stall_q + CNT_W'(1);
            if (deq) issued_q <= issued_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_q;
    assign issued_count = issued_q;
`endif

endmodule

// File: tb/tb_rv_issue_queue.sv
// tb_rv_issue_queue: directed bench for rv_issue_queue. Expected dispatch
// records are pushed to a scoreboard when an instruction is offered and
// compared/popped as the head is presented and dispatched.
module tb_rv_issue_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic [3:0]  disp_valid;
    logic [3:0]  disp_ready;
    logic [3:0]  disp_alu_op;
    logic [4:0]  disp_rs1;
    logic [4:0]  disp_rs2;
    logic [4:0]  disp_rd;
    logic [31:0] disp_imm;
    logic        disp_use_imm;
    logic        disp_is_branch;
    logic [31:0] disp_pc;
    logic        illegal;
    logic [2:0]  occupancy;
`ifdef RV_ISSUE_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] issued_count;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        rd_care;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] pc_next = 32'h100;

    always #5 clk = ~clk;

    rv_issue_queue #(
        .XLEN     (32),
        .IQ_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instr       (in_instr),
        .in_pc          (in_pc),
        .flush          (flush),
        .disp_valid     (disp_valid),
        .disp_ready     (disp_ready),
        .disp_alu_op    (disp_alu_op),
        .disp_rs1       (disp_rs1),
        .disp_rs2       (disp_rs2),
        .disp_rd        (disp_rd),
        .disp_imm       (disp_imm),
        .disp_use_imm   (disp_use_imm),
        .disp_is_branch (disp_is_branch),
        .disp_pc        (disp_pc),
        .illegal        (illegal),
        .occupancy      (occupancy)
`ifdef RV_ISSUE_PERF_CNT_EN
        ,
        .stall_cycles   (stall_cycles),
        .issued_count   (issued_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: inputs change and outputs are sampled at negedge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic offer(input logic [31:0] instr, input logic [3:0] valid,
                         input logic [3:0] op, input logic [4:0] rd,
                         input logic rd_care, input bit push);
        exp_t e;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc_next;
        if (push) begin
            e.valid   = valid;
            e.op      = op;
            e.rd      = rd;
            e.rd_care = rd_care;
            e.pc      = pc_next;
            sb.push_back(e);
        end
        pc_next = pc_next + 32'd4;
    endtask

    task automatic expect_head(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: observed=empty-scoreboard expected=entry", tag);
        end else begin
            e = sb[0];
            chk({tag, ".valid"}, 32'(disp_valid), 32'(e.valid));
            chk({tag, ".op"}, 32'(disp_alu_op), 32'(e.op));
            chk({tag, ".pc"}, disp_pc, e.pc);
            if (e.rd_care) chk({tag, ".rd"}, 32'(disp_rd), 32'(e.rd));
        end
    endtask

    task automatic pop();
        if (sb.size() != 0) void'(sb.pop_front());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_instr   = '0;
        in_pc      = '0;
        flush      = 1'b0;
        disp_ready = 4'h0;
        cyc();
        cyc();
        chk("rst.occ", 32'(occupancy), 32'd0);
        chk("rst.valid", 32'(disp_valid), 32'd0);
        chk("rst.illegal", 32'(illegal), 32'd0);
        rst_n = 1'b1;
        cyc();
        chk("rst.in_ready", 32'(in_ready), 32'd1);

        // add x3,x1,x2 straight through
        disp_ready = 4'hF;
        offer(32'h002081B3, 4'b0100, 4'd0, 5'd3, 1'b1, 1'b1);
        cyc();
        in_valid = 1'b0;
        chk("add.occ", 32'(occupancy), 32'd1);
        expect_head("add");
        chk("add.rs1", 32'(disp_rs1), 32'd1);
        chk("add.rs2", 32'(disp_rs2), 32'd2);
        chk("add.use_imm", 32'(disp_use_imm), 32'd0);
        cyc();
        pop();
        chk("add.drain", 32'(occupancy), 32'd0);
        chk("add.idle", 32'(disp_valid), 32'd0);

        // mul stalled five cycles on MULDIV, lw queued behind it
        do_reset();
        disp_ready = 4'b0111;
        offer(32'h022081B3, 4'b1000, 4'd6, 5'd3, 1'b1, 1'b1);
        cyc();
        offer(32'h0080A283, 4'b0001, 4'd0, 5'd5, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            expect_head("mul.stall");
            cyc();
            in_valid = 1'b0;
        end
        chk("mul.occ", 32'(occupancy), 32'd2);
        disp_ready = 4'hF;
        expect_head("mul.go");
        cyc();
        pop();
        expect_head("lw");
        chk("lw.imm", disp_imm, 32'd8);
        chk("lw.use_imm", 32'(disp_use_imm), 32'd1);
        chk("lw.rs1", 32'(disp_rs1), 32'd1);
        cyc();
        pop();
        chk("lw.drain", 32'(occupancy), 32'd0);
`ifdef RV_ISSUE_PERF_CNT_EN
        chk("perf.stall", stall_cycles, 32'd5);
        chk("perf.issued", issued_count, 32'd2);
`endif

        // fill to capacity with ready low
        disp_ready = 4'h0;
        for (int i = 0; i < 4; i++) begin
            offer(32'h00208033 | (32'(10 + i) << 7), 4'b0100, 4'd0, 5'(10 + i), 1'b1, 1'b1);
            cyc();
        end
        offer(32'h00208033 | (32'd20 << 7), 4'b0100, 4'd0, 5'd20, 1'b1, 1'b0);
        chk("full.in_ready", 32'(in_ready), 32'd0);
        chk("full.occ", 32'(occupancy), 32'd4);
        cyc();
        chk("full.reject", 32'(occupancy), 32'd4);
        in_valid   = 1'b0;
        disp_ready = 4'b0100;
        expect_head("full.head");
        chk("full.deq_cycle_ready", 32'(in_ready), 32'd0);
        cyc();
        pop();
        disp_ready = 4'h0;
        chk("full.after_occ", 32'(occupancy), 32'd3);
        chk("full.after_ready", 32'(in_ready), 32'd1);
        disp_ready = 4'hF;
        for (int i = 0; i < 3; i++) begin
            expect_head("full.drain");
            cyc();
            pop();
        end
        chk("full.empty", 32'(occupancy), 32'd0);

        // immediates: addi, sw, jal, sub
        disp_ready = 4'h0;
        offer(32'hFFF00093, 4'b0100, 4'd0, 5'd1, 1'b1, 1'b1);
        cyc();
        offer(32'h0050A623, 4'b0010, 4'd0, 5'd0, 1'b0, 1'b1);
        cyc();
        offer(32'h008000EF, 4'b0100, 4'd0, 5'd1, 1'b1, 1'b1);
        cyc();
        offer(32'h402081B3, 4'b0100, 4'd1, 5'd3, 1'b1, 1'b1);
        cyc();
        in_valid = 1'b0;
        expect_head("addi");
        chk("addi.imm", disp_imm, 32'hFFFFFFFF);
        chk("addi.use_imm", 32'(disp_use_imm), 32'd1);
        chk("addi.branch", 32'(disp_is_branch), 32'd0);
        disp_ready = 4'hF;
        cyc();
        pop();
        expect_head("sw");
        chk("sw.imm", disp_imm, 32'd12);
        chk("sw.rs2", 32'(disp_rs2), 32'd5);
        chk("sw.rs1", 32'(disp_rs1), 32'd1);
        cyc();
        pop();
        expect_head("jal");
        chk("jal.imm", disp_imm, 32'd8);
        chk("jal.branch", 32'(disp_is_branch), 32'd1);
        chk("jal.use_imm", 32'(disp_use_imm), 32'd1);
        cyc();
        pop();
        expect_head("sub");
        chk("sub.use_imm", 32'(disp_use_imm), 32'd0);
        cyc();
        pop();
        chk("imm.empty", 32'(occupancy), 32'd0);

        // illegal head blocks, enqueue continues, flush clears
        offer(32'hFFFFFFFF, 4'b0000, 4'd0, 5'd0, 1'b0, 1'b0);
        cyc();
        in_valid = 1'b0;
        chk("ill.pre_valid", 32'(disp_valid), 32'd0);
        cyc();
        chk("ill.flag", 32'(illegal), 32'd1);
        chk("ill.valid", 32'(disp_valid), 32'd0);
        offer(32'h002081B3, 4'b0100, 4'd0, 5'd3, 1'b1, 1'b0);
        cyc();
        chk("ill.enq_behind", 32'(occupancy), 32'd2);
        chk("ill.sticky", 32'(illegal), 32'd1);
        flush = 1'b1;
        offer(32'h002081B3, 4'b0100, 4'd0, 5'd3, 1'b1, 1'b0);
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush.occ", 32'(occupancy), 32'd0);
        chk("flush.illegal", 32'(illegal), 32'd0);
        chk("flush.valid", 32'(disp_valid), 32'd0);
        cyc();
        chk("flush.dropped", 32'(occupancy), 32'd0);
        offer(32'h022081B3, 4'b1000, 4'd6, 5'd3, 1'b1, 1'b1);
        cyc();
        in_valid = 1'b0;
        expect_head("post_flush");
        cyc();
        pop();

        // async reset in the middle of a stall
        disp_ready = 4'h0;
        offer(32'h022081B3, 4'b1000, 4'd6, 5'd3, 1'b1, 1'b1);
        cyc();
        in_valid = 1'b0;
        cyc();
        chk("mid.occ_before", 32'(occupancy), 32'd1);
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("mid.occ", 32'(occupancy), 32'd0);
        chk("mid.valid", 32'(disp_valid), 32'd0);
`ifdef RV_ISSUE_PERF_CNT_EN
        chk("mid.stall", stall_cycles, 32'd0);
        chk("mid.issued", issued_count, 32'd0);
`endif
        cyc();
        rst_n = 1'b1;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv_issue_queue.md
Name: rv_issue_queue

Overview:
- Parametrised successor to the combinational decoder: a DEPTH-entry in-order instruction queue with full RV32IM-subset decode, immediate generation and per-class dispatch handshakes.
- Sits between fetch and the Tomasulo reservation stations (LOAD, STORE, ALU, MULDIV).
- Holds the head instruction in place while its target station is full; supports flush and sticky illegal-instruction detection.

Parameters:
- XLEN, 32, data and PC width; immediates are sign-extended to XLEN.
- IQ_DEPTH, 4, queue entries; power of two, minimum 2.
- CNT_W, 32, performance-counter width; used only under the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  queue can accept; equals occupancy < IQ_DEPTH.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- flush  in  1  synchronous queue clear.
- disp_valid  out  4  one-hot dispatch request; bit 0 LOAD, 1 STORE, 2 ALU, 3 MULDIV.
- disp_ready  in  4  per-class reservation station has a free slot.
- disp_alu_op  out  4  operation code, values listed under Behaviour.
- disp_rs1, disp_rs2, disp_rd  out  5 each  register indices.
- disp_imm  out  XLEN  sign-extended immediate.
- disp_use_imm  out  1  operand B is the immediate.
- disp_is_branch  out  1  instruction is beq or jal.
- disp_pc  out  XLEN  PC of the head instruction.
- illegal  out  1  sticky: head instruction is undecodable.
- occupancy  out  $clog2(IQ_DEPTH)+1  number of valid entries.

Behaviour:
- Reset (async, rst_n=0): read/write pointers and occupancy cleared to 0; illegal=0; disp_valid=0; in_ready=1 once reset is released.
- Enqueue: occurs when in_valid && in_ready at the clock edge.
- Full queue: in_ready depends on occupancy only, so a same-cycle dequeue does not open a slot.
- Pointers wrap modulo IQ_DEPTH.
- Decode is combinational from the registered head entry.
  - Latency: an instruction enqueued at edge N is presented at edge N+1 if the queue was empty; dispatch completes at the next edge at which disp_ready[class] is high.
- Dispatch: disp_valid[c] = !empty && !illegal && class==c.
  - Dequeue on disp_valid[c] && disp_ready[c].
  - Payload is held stable while valid is stalled.
- Class and operation decode:
  - lw (0000011): LOAD, op ADD, I-immediate, use_imm=1.
  - sw (0100011): STORE, op ADD, S-immediate.
  - R-type (0110011):
    - funct7=0000001 selects MULDIV: funct3 000 MUL=6, 001 MULH=12, 100 DIV=7, 101 DIVU=13, 110 REM=14, 111 REMU=15.
    - Otherwise ALU: 000 ADD=0 or SUB=1 (funct7 bit 5), 111 AND=2, 110 OR=3, 100 XOR=4, 010 SLT=5, 011 SLTU=11, 001 SLL=8, 101 SRL=9 or SRA=10 (funct7 bit 5).
  - I-type ALU (0010011): same ALU mapping as R-type; SUB not possible; use_imm=1.
  - beq (1100011): ALU, op SUB, B-immediate, is_branch=1.
  - jal (1101111): ALU, op ADD, J-immediate, is_branch=1, use_imm=1.
- Illegal instruction: any other opcode, or an unlisted funct7 on R-type.
  - illegal is set in the cycle after the instruction reaches the head.
  - The head stays blocked; enqueue continues until the queue is full.
- Flush: at the next edge, occupancy and pointers go to 0 and illegal is cleared.
  - Flush has priority over a same-cycle enqueue and dispatch; both are dropped.
  - disp_valid is still driven during the flush cycle, but a handshake in that cycle is ignored by this block.

Optional Feature:
- Macro: RV_ISSUE_PERF_CNT_EN.
- When defined:
  - Adds outputs stall_cycles[CNT_W-1:0], incremented each cycle where disp_valid is non-zero and the matching disp_ready is 0.
  - Adds outputs issued_count[CNT_W-1:0], incremented on each dispatch.
  - Both counters wrap, reset to 0, and are unaffected by flush.
- When undefined: the ports and logic are absent.

Decomposition:
- Package rv_issue_pkg holds:
  - opcode localparams;
  - alu_op_e (4-bit enum);
  - class_e with LOAD=0, STORE=1, ALU=2, MULDIV=3;
  - struct decoded_t (class, op, rs1, rs2, rd, imm, use_imm, is_branch, legal).
- Sub-module rv_issue_decode: purely combinational, instr to decoded_t.
- Queue storage and control stay in the top level.

Test Plan:
- Reset, then enqueue add x3,x1,x2 (0x002081B3) with disp_ready=4'hF → disp_valid=4'b0100, op=0, rd=3; occupancy returns to 0.
- Enqueue mul (0x022081B3) then lw x5,8(x1) (0x0080A283) with disp_ready[3]=0 for 5 cycles → mul held stable, lw not dispatched; mul is released when ready rises, lw issues on LOAD next, imm=8.
- Fill 4 entries with disp_ready=0 → in_ready=0 and a 5th offer is not accepted; raise ready for one cycle → one dequeue, in_ready still 0 in that cycle and 1 after.
- Enqueue addi x1,x0,-1 (0xFFF00093) → imm=0xFFFFFFFF, use_imm=1; enqueue sw x5,12(x1) (0x0050A623) → STORE, imm=12, rs2=5.
- Enqueue 0xFFFFFFFF → illegal=1, disp_valid=0; assert flush with a concurrent in_valid → occupancy=0, illegal=0, offered instruction dropped.
- With RV_ISSUE_PERF_CNT_EN, replay the stall scenario → stall_cycles=5, issued_count=2; deassert rst_n mid-stall → counters and queue are 0 immediately.
